// File: rtl/mul_cell_arbiter_if.sv
// Requester-side bus of the shared multiplier arbiter: per-requester request
// and response handshakes plus the single shared result bus.
interface mul_cell_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*32-1:0] req_src1;
   logic [NUM_REQ*32-1:0] req_src2;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [NUM_REQ-1:0]    rsp_ready;
   logic [31:0]           rsp_data;

   modport master (
      output req_valid, req_src1, req_src2, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_src1, req_src2, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/mul_cell_arbiter.sv
// Round-robin arbiter sharing one 3-partial-product 16x16 multiplier cell among
// NUM_REQ requesters; returns the low 32 bits of src1*src2 per request.
module mul_cell_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   mul_cell_arbiter_if.slave bus,
   output logic [31:0]       mul_src1,
   output logic [31:0]       mul_src2,
   output logic              mul_en,
   input  logic [31:0]       mul_p1,
   input  logic [31:0]       mul_p2,
   input  logic [31:0]       mul_p3,
   output logic              busy,
   output logic [ID_W-1:0]   grant_id
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_CAPTURE,
      ST_RESP
   } state_t;

   localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

   state_t          state_reg, state_next;
   logic [ID_W-1:0] rr_ptr_reg, rr_ptr_next;
   logic [ID_W-1:0] grant_reg, grant_next;
   logic [31:0]     src1_reg, src1_next;
   logic [31:0]     src2_reg, src2_next;
   logic [31:0]     rsp_data_reg, rsp_data_next;

   logic [31:0]     op_a [NUM_REQ];
   logic [31:0]     op_b [NUM_REQ];
   logic [ID_W:0]   cand [NUM_REQ];
   logic [NUM_REQ-1:0] cand_valid;

   logic            win_found;
   logic [ID_W-1:0] win_idx;
   logic [ID_W:0]   grant_inc;
   logic [ID_W-1:0] grant_wrap;

   // cand[k] is the requester searched k-th, starting from rr_ptr and wrapping
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
         logic [ID_W:0] slot_sum;

         assign op_a[gi]       = bus.req_src1[32*gi +: 32];
         assign op_b[gi]       = bus.req_src2[32*gi +: 32];
         assign slot_sum       = {1'b0, rr_ptr_reg} + (ID_W+1)'(gi);
         assign cand[gi]       = (slot_sum >= NUM_REQ_W) ? (slot_sum - NUM_REQ_W) : slot_sum;
         assign cand_valid[gi] = bus.req_valid[cand[gi][ID_W-1:0]];

         assign bus.req_ready[gi] = reset_n && (state_reg == ST_IDLE) && win_found
                                    && (win_idx == ID_W'(gi));
         assign bus.rsp_valid[gi] = (state_reg == ST_RESP) && (grant_reg == ID_W'(gi));
      end
   endgenerate

   // Scan from the far end so the nearest candidate to rr_ptr is the last write
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (cand_valid[k]) begin
            win_found = 1'b1;
            win_idx   = cand[k][ID_W-1:0];
         end
      end
   end

   assign grant_inc  = {1'b0, grant_reg} + (ID_W+1)'(1);
   assign grant_wrap = (grant_inc >= NUM_REQ_W) ? '0 : grant_inc[ID_W-1:0];

   always_comb begin
      state_next    = state_reg;
      rr_ptr_next   = rr_ptr_reg;
      grant_next    = grant_reg;
      src1_next     = src1_reg;
      src2_next     = src2_reg;
      rsp_data_next = rsp_data_reg;
      case (state_reg)
         ST_IDLE: begin
            if (win_found) begin
               grant_next = win_idx;
               src1_next  = op_a[win_idx];
               src2_next  = op_b[win_idx];
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_next = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            // Low 32 bits only: the hi*hi term and cross-term carries fall off the top
            rsp_data_next = mul_p1 + ((mul_p2 + mul_p3) << 16);
            state_next    = ST_RESP;
         end
         ST_RESP: begin
            if (bus.rsp_ready[grant_reg]) begin
               rr_ptr_next = grant_wrap;
               state_next  = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= ST_IDLE;
         rr_ptr_reg   <= '0;
         grant_reg    <= '0;
         src1_reg     <= '0;
         src2_reg     <= '0;
         rsp_data_reg <= '0;
      end else begin
         state_reg    <= state_next;
         rr_ptr_reg   <= rr_ptr_next;
         grant_reg    <= grant_next;
         src1_reg     <= src1_next;
         src2_reg     <= src2_next;
         rsp_data_reg <= rsp_data_next;
      end
   end

   assign mul_src1     = src1_reg;
   assign mul_src2     = src2_reg;
   assign mul_en       = (state_reg == ST_ISSUE);
   assign busy         = (state_reg != ST_IDLE);
   assign grant_id     = grant_reg;
   assign bus.rsp_data = rsp_data_reg;

endmodule
